// File: rtl/mtc_tx_pkg.sv
// Shared constants, FSM encoding and beat slicing for the MTC2SL TX buffer.
package mtc_tx_pkg;

    // Mirrors the candidate width from the l0mdt buses constants.
    localparam int unsigned MTC2SL_LEN = 193;
    localparam int unsigned N_CAND     = 2;
    localparam int unsigned LINK_W     = 64;
    localparam int unsigned N_BEATS    = (MTC2SL_LEN + LINK_W - 1) / LINK_W;
    localparam int unsigned BEAT_W     = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam int unsigned PAD_W      = N_BEATS * LINK_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

    typedef logic [MTC2SL_LEN-1:0] cand_t;

    // Beat idx of a candidate; the top beat is zero-padded above the word.
    function automatic logic [LINK_W-1:0] beat_sel(input cand_t word, input logic [BEAT_W-1:0] idx);
        logic [PAD_W-1:0] padded;
        padded = PAD_W'(word);
        return padded[32'(idx)*LINK_W +: LINK_W];
    endfunction

endpackage

// File: rtl/mtc_tx_fifo.sv
// Sync FIFO with two in-order write ports, one pop and a clearing flush.
module mtc_tx_fifo #(
    parameter int unsigned WIDTH = 193,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [2*WIDTH-1:0]           i_wr_data,
    input  logic [1:0]                   i_wr_valid,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output logic [WIDTH-1:0]             o_head,
    output logic [$clog2(DEPTH):0]       o_count,
    output logic [1:0]                   o_drop_c
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] free;
    logic             pop_ok;
    logic             acc0;
    logic             acc1;

    // Room is judged after this cycle's pop, so a full FIFO being read still takes one write.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        o_drop_c = 2'd0;
        pop_ok   = i_pop && (count_q != '0);
        free     = CNT_W'(DEPTH) - count_q + CNT_W'(pop_ok);
        acc0     = i_wr_valid[0] && (free != '0);
        acc1     = i_wr_valid[1] && ((free - CNT_W'(acc0)) != '0);
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (acc0) mem_d[wr_ptr_q] = i_wr_data[0 +: WIDTH];
            if (acc1) mem_d[wr_ptr_q + AW'(acc0)] = i_wr_data[WIDTH +: WIDTH];
            wr_ptr_d = wr_ptr_q + AW'(acc0) + AW'(acc1);
            rd_ptr_d = rd_ptr_q + AW'(pop_ok);
            count_d  = count_q - CNT_W'(pop_ok) + CNT_W'(acc0) + CNT_W'(acc1);
            o_drop_c = 2'(i_wr_valid[0] && !acc0) + 2'(i_wr_valid[1] && !acc1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule

// File: rtl/mtc2sl_tx_buffer.sv
// Buffers MTC2SL candidates and serialises each into LINK_W beats toward the SL link TX.
module mtc2sl_tx_buffer
    import mtc_tx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_CAND*MTC2SL_LEN-1:0]   i_mtc_data,
    input  logic [N_CAND-1:0]              i_mtc_valid,
    input  logic                           i_flush,
    output logic [LINK_W-1:0]              o_tx_data,
    output logic                           o_tx_valid,
    output logic                           o_tx_first,
    output logic                           o_tx_last,
    input  logic                           i_tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]    o_fifo_count,
    output logic [15:0]                    o_drop_cnt,
    output logic                           o_overflow
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

    tx_state_t         state_q, state_d;
    cand_t             sr_q, sr_d;
    logic [BEAT_W-1:0] b_q, b_d;
    logic [LINK_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              first_q, first_d;
    logic              last_q, last_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic              overflow_q, overflow_d;

    cand_t             fifo_head;
    logic [1:0]        drop_c;
    logic              pop_c;
    logic              fifo_ne;
    logic              xfer;
    logic [16:0]       drop_sum;

    mtc_tx_fifo #(
        .WIDTH (MTC2SL_LEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_wr_data  (i_mtc_data),
        .i_wr_valid (i_mtc_valid),
        .i_pop      (pop_c),
        .i_flush    (i_flush),
        .o_head     (fifo_head),
        .o_count    (o_fifo_count),
        .o_drop_c   (drop_c)
    );

    assign fifo_ne = (o_fifo_count != '0);
    assign xfer    = valid_q && i_tx_ready;

    // Beat sequencer: the output registers are loaded with the beat to present next cycle.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        b_d     = b_q;
        data_d  = data_q;
        valid_d = valid_q;
        first_d = first_q;
        last_d  = last_q;
        pop_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_ne) begin
                    pop_c   = 1'b1;
                    sr_d    = fifo_head;
                    b_d     = '0;
                    data_d  = beat_sel(fifo_head, '0);
                    valid_d = 1'b1;
                    first_d = 1'b1;
                    last_d  = (N_BEATS == 1);
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (b_q == LAST_BEAT) begin
                        if (fifo_ne) begin
                            pop_c   = 1'b1;
                            sr_d    = fifo_head;
                            b_d     = '0;
                            data_d  = beat_sel(fifo_head, '0);
                            valid_d = 1'b1;
                            first_d = 1'b1;
                            last_d  = (N_BEATS == 1);
                        end else begin
                            b_d     = '0;
                            data_d  = '0;
                            valid_d = 1'b0;
                            first_d = 1'b0;
                            last_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        b_d     = b_q + BEAT_W'(1);
                        data_d  = beat_sel(sr_q, b_d);
                        first_d = 1'b0;
                        last_d  = (b_d == LAST_BEAT);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Drop counter saturates; overflow stays set until reset.
    always_comb begin
        drop_sum   = 17'(drop_cnt_q) + 17'(drop_c);
        drop_cnt_d = (drop_sum > 17'h0FFFF) ? 16'hFFFF : drop_sum[15:0];
        overflow_d = overflow_q | (drop_c != 2'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            b_q        <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            b_q        <= b_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            first_q    <= first_d;
            last_q     <= last_d;
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_tx_data  = data_q;
    assign o_tx_valid = valid_q;
    assign o_tx_first = first_q;
    assign o_tx_last  = last_q;
    assign o_drop_cnt = drop_cnt_q;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_mtc2sl_tx_buffer.sv
// Directed bench for mtc2sl_tx_buffer: per-cycle vector table plus corner-case sequences.
module tb_mtc2sl_tx_buffer;

    localparam logic [192:0] CAND_A = {1'b1, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0011223344556677};
    localparam logic [192:0] CAND_B = {1'b0, 64'hCAFEBABEDEADBEEF, 64'h1111111111111111, 64'h2222222222222222};

    logic         clk = 1'b0;
    logic         rst;
    logic [385:0] mtc_data;
    logic [1:0]   mtc_valid;
    logic         flush;
    logic [63:0]  tx_data;
    logic         tx_valid;
    logic         tx_first;
    logic         tx_last;
    logic         tx_ready;
    logic [3:0]   fifo_count;
    logic [15:0]  drop_cnt;
    logic         overflow;

    logic [63:0]  a_beat [4];
    logic [63:0]  b_beat [4];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  wv;
        logic        rdy;
        logic        ev;
        logic        ef;
        logic        el;
        logic [63:0] ed;
        logic [3:0]  ec;
    } vec_t;

    vec_t vecs[$];

    mtc2sl_tx_buffer #(.FIFO_DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_mtc_data   (mtc_data),
        .i_mtc_valid  (mtc_valid),
        .i_flush      (flush),
        .o_tx_data    (tx_data),
        .o_tx_valid   (tx_valid),
        .o_tx_first   (tx_first),
        .o_tx_last    (tx_last),
        .i_tx_ready   (tx_ready),
        .o_fifo_count (fifo_count),
        .o_drop_cnt   (drop_cnt),
        .o_overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] wv, input logic rdy, input logic ev, input logic ef,
                       input logic el, input logic [63:0] ed, input logic [3:0] ec);
        vec_t v;
        v.wv = wv; v.rdy = rdy; v.ev = ev; v.ef = ef; v.el = el; v.ed = ed; v.ec = ec;
        vecs.push_back(v);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},     tx_data, 64'd0);
        check({tag, "_valid"},    64'(tx_valid), 64'd0);
        check({tag, "_first"},    64'(tx_first), 64'd0);
        check({tag, "_last"},     64'(tx_last), 64'd0);
        check({tag, "_count"},    64'(fifo_count), 64'd0);
        check({tag, "_drop"},     64'(drop_cnt), 64'd0);
        check({tag, "_overflow"}, 64'(overflow), 64'd0);
    endtask

    initial begin
        logic hit;
        int   n;

        a_beat[0] = 64'h0011223344556677; a_beat[1] = 64'hFEDCBA9876543210;
        a_beat[2] = 64'h0123456789ABCDEF; a_beat[3] = 64'h0000000000000001;
        b_beat[0] = 64'h2222222222222222; b_beat[1] = 64'h1111111111111111;
        b_beat[2] = 64'hCAFEBABEDEADBEEF; b_beat[3] = 64'h0000000000000000;

        mtc_data  = {CAND_B, CAND_A};
        mtc_valid = 2'b00;
        flush     = 1'b0;
        tx_ready  = 1'b1;
        rst       = 1'b1;
        #2 rst = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Single candidate: written at row 0, beats at rows 2..5.
        add(2'b01, 1, 0, 0, 0, 64'd0,     4'd0);
        add(2'b00, 1, 0, 0, 0, 64'd0,     4'd1);
        add(2'b00, 1, 1, 1, 0, a_beat[0], 4'd0);
        add(2'b00, 1, 1, 0, 0, a_beat[1], 4'd0);
        add(2'b00, 1, 1, 0, 0, a_beat[2], 4'd0);
        add(2'b00, 1, 1, 0, 1, a_beat[3], 4'd0);
        add(2'b00, 1, 0, 0, 0, 64'd0,     4'd0);
        // Dual write: slot 0 then slot 1, eight beats with no gap.
        add(2'b11, 1, 0, 0, 0, 64'd0,     4'd0);
        add(2'b00, 1, 0, 0, 0, 64'd0,     4'd2);
        add(2'b00, 1, 1, 1, 0, a_beat[0], 4'd1);
        add(2'b00, 1, 1, 0, 0, a_beat[1], 4'd1);
        add(2'b00, 1, 1, 0, 0, a_beat[2], 4'd1);
        add(2'b00, 1, 1, 0, 1, a_beat[3], 4'd1);
        add(2'b00, 1, 1, 1, 0, b_beat[0], 4'd0);
        add(2'b00, 1, 1, 0, 0, b_beat[1], 4'd0);
        add(2'b00, 1, 1, 0, 0, b_beat[2], 4'd0);
        add(2'b00, 1, 1, 0, 1, b_beat[3], 4'd0);
        add(2'b00, 1, 0, 0, 0, 64'd0,     4'd0);
        // Backpressure: ready low for five cycles while beat 1 is presented.
        add(2'b01, 1, 0, 0, 0, 64'd0,     4'd0);
        add(2'b00, 1, 0, 0, 0, 64'd0,     4'd1);
        add(2'b00, 1, 1, 1, 0, a_beat[0], 4'd0);
        for (int k = 0; k < 5; k++) add(2'b00, 0, 1, 0, 0, a_beat[1], 4'd0);
        add(2'b00, 1, 1, 0, 0, a_beat[1], 4'd0);
        add(2'b00, 1, 1, 0, 0, a_beat[2], 4'd0);
        add(2'b00, 1, 1, 0, 1, a_beat[3], 4'd0);
        add(2'b00, 1, 0, 0, 0, 64'd0,     4'd0);

        foreach (vecs[i]) begin
            @(negedge clk);
            mtc_valid = vecs[i].wv;
            tx_ready  = vecs[i].rdy;
            check($sformatf("vec%0d_valid", i), 64'(tx_valid), 64'(vecs[i].ev));
            check($sformatf("vec%0d_count", i), 64'(fifo_count), 64'(vecs[i].ec));
            if (vecs[i].ev) begin
                check($sformatf("vec%0d_data", i),  tx_data, vecs[i].ed);
                check($sformatf("vec%0d_first", i), 64'(tx_first), 64'(vecs[i].ef));
                check($sformatf("vec%0d_last", i),  64'(tx_last), 64'(vecs[i].el));
            end
        end
        @(negedge clk);
        mtc_valid = 2'b00;
        check("table_no_drops", 64'(drop_cnt), 64'd0);

        // Overflow: five dual writes with the sink stalled.
        tx_ready  = 1'b0;
        mtc_valid = 2'b11;
        repeat (5) @(negedge clk);
        mtc_valid = 2'b00;
        check("ovf_count", 64'(fifo_count), 64'd8);
        check("ovf_drop1", 64'(drop_cnt), 64'd1);
        check("ovf_sticky", 64'(overflow), 64'd1);
        check("ovf_inflight", tx_data, a_beat[0]);
        mtc_valid = 2'b11;
        @(negedge clk);
        mtc_valid = 2'b00;
        check("ovf_drop3", 64'(drop_cnt), 64'd3);
        check("ovf_count_full", 64'(fifo_count), 64'd8);

        // Full FIFO popping on the last beat accepts exactly one write.
        tx_ready = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (tx_last) begin
                mtc_valid = 2'b11;
                hit = 1'b1;
            end
            @(negedge clk);
            if (hit) break;
        end
        mtc_valid = 2'b00;
        check("fullpop_reached_last", 64'(hit), 64'd1);
        check("fullpop_count", 64'(fifo_count), 64'd8);
        check("fullpop_drop4", 64'(drop_cnt), 64'd4);
        check("fullpop_first", 64'(tx_first), 64'd1);
        check("fullpop_next_head", tx_data, b_beat[0]);

        hit = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!tx_valid) begin
                hit = 1'b1;
                break;
            end
        end
        check("drain_done", 64'(hit), 64'd1);
        check("drain_count", 64'(fifo_count), 64'd0);

        // Flush: three queued plus one in flight; in-flight candidate still completes.
        tx_ready  = 1'b0;
        mtc_valid = 2'b11;
        @(negedge clk);
        @(negedge clk);
        check("flush_pre_count", 64'(fifo_count), 64'd3);
        check("flush_pre_valid", 64'(tx_valid), 64'd1);
        mtc_valid = 2'b01;
        flush     = 1'b1;
        @(negedge clk);
        mtc_valid = 2'b00;
        flush     = 1'b0;
        check("flush_count", 64'(fifo_count), 64'd0);
        check("flush_drop_kept", 64'(drop_cnt), 64'd4);
        check("flush_ovf_kept", 64'(overflow), 64'd1);
        tx_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (!tx_valid) break;
            if (n < 4) begin
                check($sformatf("flush_beat%0d_data", n), tx_data, a_beat[n]);
                check($sformatf("flush_beat%0d_first", n), 64'(tx_first), 64'(n == 0));
                check($sformatf("flush_beat%0d_last", n), 64'(tx_last), 64'(n == 3));
            end
            n++;
            @(negedge clk);
        end
        check("flush_beats", 64'(n), 64'd4);
        check("flush_after_valid", 64'(tx_valid), 64'd0);
        check("flush_after_count", 64'(fifo_count), 64'd0);

        // Asynchronous reset while beat 2 is on the link.
        mtc_valid = 2'b01;
        @(negedge clk);
        mtc_valid = 2'b00;
        hit = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (tx_valid && tx_data == a_beat[2]) begin
                hit = 1'b1;
                break;
            end
        end
        check("rst_reached_beat2", 64'(hit), 64'd1);
        rst = 1'b0;
        #1 check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("postrst_valid%0d", k), 64'(tx_valid), 64'd0);
        end
        check("postrst_count", 64'(fifo_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
